// File: rtl/gtp_pkg.sv
// Purpose : shared types and constants for the GTP tape-image loader.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package gtp_pkg;

    // Parser states. The order follows the byte order inside a GTP block.
    typedef enum logic [3:0] {
        IDLE,
        TYPE,
        LEN_L,
        LEN_H,
        RSV0,
        RSV1,
        SYNC,
        ST_L,
        ST_H,
        EN_L,
        EN_H,
        DATA,
        CSUM,
        SKIP,
        ERROR
    } gtp_state_t;

    localparam logic [7:0] GTP_TYPE_STD     = 8'h00;
    localparam logic [7:0] GTP_SYNC         = 8'hA5;
    localparam int         GTP_HDR_BYTES    = 5;   // type, len lo/hi, two reserved
    localparam int         GTP_STD_OVERHEAD = 6;   // sync, start lo/hi, end lo/hi, checksum

    // A standard block is consistent when its declared length equals the data
    // span plus the fixed framing bytes. Done in 17 bits so a span near 0xFFFF
    // cannot wrap into a false match.
    function automatic logic std_len_ok(input logic [15:0] span, input logic [15:0] len);
        return ({1'b0, span} + 17'(GTP_STD_OVERHEAD)) == {1'b0, len};
    endfunction

endpackage

// File: rtl/gtp_wr_buf.sv
// Purpose : single-entry holding register between the GTP parser and Galaksija RAM.
// Latency : push to mem_req is 1 cycle; entry frees the cycle after mem_req && mem_ack.
// Backpressure: full stays high from the cycle after a push until the cycle after the ack.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   push, push_addr/dat latch one write (only legal while empty, or in the ack cycle)
//   full                holding register occupied (drives ioctl_wait)
//   mem_req/addr/dout   RAM write request, address and data held stable until ack
//   mem_ack             RAM accepts on mem_req && mem_ack
module gtp_wr_buf #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [7:0]        push_dat,
    input  logic              mem_ack,
    output logic              full,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout
);

    logic full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
        end else if (push) begin
            // A push in the ack cycle reloads the entry: the ack retires the
            // old write and the new byte takes its place.
            full_q   <= 1'b1;
            mem_addr <= push_addr;
            mem_dout <= push_dat;
        end else if (full_q && mem_ack) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;

    // Reset withdraws the request in the same cycle so no write can slip out
    // while the loader is being torn down.
    assign mem_req = full_q && !reset;

endmodule

// File: rtl/gtp_loader.sv
// Purpose : parse a GTP tape image from the ioctl stream and write standard-block data to RAM.
// Latency : ioctl_wr strobe of a data byte to mem_req is 1 cycle.
// Backpressure: ioctl_wait is high while a RAM write is pending; strobes then are not accepted.
//
// Ports:
//   clk_sys, reset                  system clock, synchronous active-high reset
//   ioctl_download/wr/dout          download window, byte strobe, byte
//   ioctl_wait                      holding register full
//   mem_addr/dout/req, mem_ack      RAM write handshake
//   load_done                       one-cycle pulse at a clean end of download
//   load_err                        sticky error until the next download starts
//   start_addr/end_addr             first block start, last block end
// Optional: define GTP_CHECKSUM_EN to verify the per-block checksum (sum must be 0xFF).
module gtp_loader
    import gtp_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int MAX_BLOCKS = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] end_addr
);

    localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

    gtp_state_t        state;
    logic              dl_q;
    logic              fin_pend;     // download ended, waiting for the last RAM write
    logic              first_std;    // next standard block sets start_addr
    logic              skip_blk;     // current block is not parsed, only consumed
    logic [7:0]        len_lo;
    logic [7:0]        st_lo;
    logic [7:0]        en_lo;
    logic [15:0]       rem;          // block length; counts down while skipping
    logic [15:0]       st_q;
    logic [15:0]       dcnt;         // data bytes still expected in DATA
    logic [ADDR_W-1:0] addr_cnt;
    logic [CNT_W-1:0]  blk_cnt;

    logic              buf_full;
    logic              ack_now;
    logic              dl_rise;
    logic              dl_fall;
    logic              byte_acc;
    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic [15:0]       end_w;
    logic [15:0]       span;

    assign ack_now  = buf_full && mem_ack;
    assign dl_rise  = ioctl_download && !dl_q;
    assign dl_fall  = dl_q && !ioctl_download;
    assign byte_acc = ioctl_wr && (!buf_full || ack_now) && (state != IDLE)
                      && !fin_pend && !dl_fall;
    assign push     = byte_acc && (state == DATA);
    // When an ack and a strobe coincide the ack is retired first, so the new
    // byte belongs at the already-incremented address.
    assign push_addr = ack_now ? addr_cnt + 1'b1 : addr_cnt;
    assign end_w    = {ioctl_dout, en_lo};
    assign span     = end_w - st_q;
    assign ioctl_wait = buf_full;

    gtp_wr_buf #(.ADDR_W(ADDR_W)) u_wr_buf (
        .clk       (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_addr (push_addr),
        .push_dat  (ioctl_dout),
        .mem_ack   (mem_ack),
        .full      (buf_full),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout)
    );

`ifdef GTP_CHECKSUM_EN
    // Running sum from the start-address low byte onward; restarted at ST_L so
    // earlier blocks never leak into it.
    logic [7:0] csum;
    logic       csum_bad;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csum <= '0;
        end else if (byte_acc) begin
            if (state == ST_L) begin
                csum <= ioctl_dout;
            end else begin
                csum <= csum + ioctl_dout;
            end
        end
    end

    assign csum_bad = (csum + ioctl_dout) != 8'hFF;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            fin_pend   <= 1'b0;
            first_std  <= 1'b0;
            skip_blk   <= 1'b0;
            len_lo     <= '0;
            st_lo      <= '0;
            en_lo      <= '0;
            rem        <= '0;
            st_q       <= '0;
            dcnt       <= '0;
            addr_cnt   <= '0;
            blk_cnt    <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            start_addr <= '0;
            end_addr   <= '0;
        end else begin
            dl_q      <= ioctl_download;
            load_done <= 1'b0;

            if (ack_now) begin
                addr_cnt <= addr_cnt + 1'b1;
            end

            if (state == IDLE) begin
                if (dl_rise) begin
                    state     <= TYPE;
                    load_err  <= 1'b0;
                    blk_cnt   <= '0;
                    first_std <= 1'b1;
                end
            end else if (fin_pend || dl_fall) begin
                // The image is complete only if it ended on a block boundary;
                // judge that after the last RAM write has retired.
                fin_pend <= 1'b1;
                if (!buf_full) begin
                    fin_pend <= 1'b0;
                    state    <= IDLE;
                    if (state != TYPE) begin
                        load_err <= 1'b1;
                    end else begin
                        load_done <= !load_err;
                    end
                end
            end else if (byte_acc) begin
                case (state)
                    TYPE: begin
                        skip_blk <= (ioctl_dout != GTP_TYPE_STD) || (int'(blk_cnt) >= MAX_BLOCKS);
                        state    <= LEN_L;
                    end
                    LEN_L: begin
                        len_lo <= ioctl_dout;
                        state  <= LEN_H;
                    end
                    LEN_H: begin
                        rem   <= {ioctl_dout, len_lo};
                        state <= RSV0;
                    end
                    RSV0: state <= RSV1;
                    RSV1: begin
                        if (skip_blk) begin
                            state <= (rem == 16'd0) ? TYPE : SKIP;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                            state   <= SYNC;
                        end
                    end
                    SKIP: begin
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state <= TYPE;
                        end
                    end
                    SYNC: begin
                        if (ioctl_dout != GTP_SYNC) begin
                            load_err <= 1'b1;
                            state    <= ERROR;
                        end else begin
                            state <= ST_L;
                        end
                    end
                    ST_L: begin
                        st_lo <= ioctl_dout;
                        state <= ST_H;
                    end
                    ST_H: begin
                        st_q  <= {ioctl_dout, st_lo};
                        state <= EN_L;
                    end
                    EN_L: begin
                        en_lo <= ioctl_dout;
                        state <= EN_H;
                    end
                    EN_H: begin
                        if ((end_w < st_q) || !std_len_ok(span, rem)) begin
                            load_err <= 1'b1;
                            state    <= ERROR;
                        end else begin
                            if (first_std) begin
                                start_addr <= ADDR_W'(st_q);
                                first_std  <= 1'b0;
                            end
                            end_addr <= ADDR_W'(end_w);
                            addr_cnt <= ADDR_W'(st_q);
                            dcnt     <= span;
                            state    <= (span == 16'd0) ? CSUM : DATA;
                        end
                    end
                    DATA: begin
                        dcnt <= dcnt - 16'd1;
                        if (dcnt == 16'd1) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
`ifdef GTP_CHECKSUM_EN
                        if (csum_bad) begin
                            load_err <= 1'b1;
                        end
`endif
                        state <= TYPE;
                    end
                    ERROR: state <= ERROR;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // hps_io must honour ioctl_wait; an ack in the same cycle frees the entry.
    a_wr_while_full: assert property (@(posedge clk_sys) disable iff (reset)
        !(ioctl_wr && ioctl_wait && !mem_ack));

endmodule

// File: tb/tb_gtp_loader.sv
// Purpose : directed bench for gtp_loader with a write scoreboard.
// Latency : expected RAM writes are queued up front and matched as the RAM model acks them.
// Backpressure: the RAM model acks after a programmable number of cycles.
module tb_gtp_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        load_done;
    logic        load_err;
    logic [15:0] start_addr;
    logic [15:0] end_addr;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_delay = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    logic [23:0] wq[$];      // expected writes {addr, data}
    logic [7:0]  stim[$];

    gtp_loader #(.ADDR_W(16), .MAX_BLOCKS(2)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .load_done      (load_done),
        .load_err       (load_err),
        .start_addr     (start_addr),
        .end_addr       (end_addr)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model and write monitor: acks each request after ack_delay cycles
    // and matches it against the head of the expected-write queue.
    initial begin : ram_mon
        int          cnt;
        logic        first;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic [23:0] e;
        cnt   = 0;
        first = 1'b1;
        a0    = '0;
        d0    = '0;
        forever begin
            @(negedge clk_sys);
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
                first   = 1'b1;
            end else if (mem_req === 1'b1) begin
                if (first) begin
                    a0    = mem_addr;
                    d0    = mem_dout;
                    first = 1'b0;
                end
                if (cnt >= ack_delay) begin
                    chk("addr_stable", mem_addr, a0);
                    chk("data_stable", mem_dout, d0);
                    chk("write_expected", wq.size() > 0, 1);
                    if (wq.size() > 0) begin
                        e = wq.pop_front();
                        chk("wr_addr", mem_addr, e[23:8]);
                        chk("wr_data", mem_dout, e[7:0]);
                    end
                    mem_ack = 1'b1;
                end else begin
                    chk("wait_while_pending", ioctl_wait, 1);
                    cnt++;
                end
            end else begin
                cnt   = 0;
                first = 1'b1;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (load_done === 1'b1) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (ioctl_wait === 1'b1 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 200) chk("wait_timeout", ioctl_wait, 0);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_byte(stim[i]);
    endtask

    task automatic start_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        done_base      = done_cnt;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic end_dl();
        int t;
        t = 0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        while ((mem_req === 1'b1 || ioctl_wait === 1'b1) && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 100) chk("drain_timeout", mem_req, 0);
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic check_status(input string tag, input int exp_done, input logic exp_err,
                                input logic chk_addr, input logic [15:0] exp_st,
                                input logic [15:0] exp_en);
        chk({tag, "_done"}, done_cnt - done_base, exp_done);
        chk({tag, "_err"}, load_err, exp_err);
        if (chk_addr) begin
            chk({tag, "_start"}, start_addr, exp_st);
            chk({tag, "_end"}, end_addr, exp_en);
        end
        chk({tag, "_writes_left"}, wq.size(), 0);
    endtask

    initial begin : main
        int seen;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_start", start_addr, 0);
        chk("rst_end", end_addr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dout", mem_dout, 0);

        // Single standard block, immediate ack.
        wq.push_back({16'h2C3A, 8'h11});
        wq.push_back({16'h2C3B, 8'h22});
        wq.push_back({16'h2C3C, 8'h33});
        start_dl();
        stim = '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3A, 8'h2C, 8'h3D, 8'h2C,
                 8'h11, 8'h22, 8'h33, 8'hCA};
        send_stim();
        end_dl();
        check_status("single", 1, 1'b0, 1'b1, 16'h2C3A, 16'h2C3D);

        // Name block skipped, then a standard block.
        wq.push_back({16'h1000, 8'hAA});
        wq.push_back({16'h1001, 8'h55});
        start_dl();
        stim = '{8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h47, 8'h41, 8'h4C, 8'h41,
                 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h10, 8'h02, 8'h10,
                 8'hAA, 8'h55, 8'hDE};
        send_stim();
        end_dl();
        check_status("name_skip", 1, 1'b0, 1'b1, 16'h1000, 16'h1002);

        // Slow RAM: five-cycle ack delay on every write.
        ack_delay = 5;
        wq.push_back({16'h2C3A, 8'h11});
        wq.push_back({16'h2C3B, 8'h22});
        wq.push_back({16'h2C3C, 8'h33});
        start_dl();
        stim = '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3A, 8'h2C, 8'h3D, 8'h2C,
                 8'h11, 8'h22, 8'h33, 8'hCA};
        send_stim();
        end_dl();
        check_status("slow_ack", 1, 1'b0, 1'b1, 16'h2C3A, 16'h2C3D);
        ack_delay = 0;

        // Bad sync byte: error, nothing written.
        start_dl();
        stim = '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h3A, 8'h2C, 8'h3D, 8'h2C,
                 8'h11, 8'h22, 8'h33, 8'hCA};
        send_stim();
        end_dl();
        check_status("bad_sync", 0, 1'b1, 1'b0, 16'h0, 16'h0);

        // Three standard blocks with a block budget of two: the third is skipped.
        wq.push_back({16'h0100, 8'h5A});
        wq.push_back({16'h0200, 8'h6B});
        start_dl();
        stim = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h01, 8'h5A, 8'hA2,
                 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h6B, 8'h8F,
                 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h03, 8'h01, 8'h03, 8'h7C, 8'h7C};
        send_stim();
        end_dl();
        check_status("max_blocks", 1, 1'b0, 1'b1, 16'h0100, 16'h0201);

        // Truncated file: download ends inside DATA.
        wq.push_back({16'h3000, 8'h01});
        wq.push_back({16'h3001, 8'h02});
        start_dl();
        stim = '{8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h30, 8'h04, 8'h30,
                 8'h01, 8'h02};
        send_stim();
        end_dl();
        check_status("truncated", 0, 1'b1, 1'b1, 16'h3000, 16'h3004);

        // end < start.
        start_dl();
        stim = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h50, 8'hFF, 8'h4F};
        send_stim();
        end_dl();
        check_status("end_lt_start", 0, 1'b1, 1'b0, 16'h0, 16'h0);

        // Checksum off by one.
        wq.push_back({16'h2C3A, 8'h11});
        wq.push_back({16'h2C3B, 8'h22});
        wq.push_back({16'h2C3C, 8'h33});
        start_dl();
        stim = '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3A, 8'h2C, 8'h3D, 8'h2C,
                 8'h11, 8'h22, 8'h33, 8'hCB};
        send_stim();
        end_dl();
`ifdef GTP_CHECKSUM_EN
        check_status("csum_off", 0, 1'b1, 1'b1, 16'h2C3A, 16'h2C3D);
`else
        check_status("csum_off", 1, 1'b0, 1'b1, 16'h2C3A, 16'h2C3D);
`endif

        // Reset while a write is pending.
        ack_delay = 30;
        wq.push_back({16'h6000, 8'h99});
        start_dl();
        stim = '{8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h60, 8'h02, 8'h60, 8'h99};
        send_stim();
        repeat (2) @(negedge clk_sys);
        chk("rst_mid_req_before", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_req_drop", mem_req, 0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("rst_mid_wait", ioctl_wait, 0);
        chk("rst_mid_err", load_err, 0);
        chk("rst_mid_start", start_addr, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_unwritten", wq.size(), 1);
        if (wq.size() > 0) void'(wq.pop_front());
        seen = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (mem_req === 1'b1) seen++;
        end
        chk("rst_mid_no_write", seen, 0);
        ack_delay = 0;

        // end == start: no data bytes, straight to checksum.
        start_dl();
        stim = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h40, 8'h00, 8'h40, 8'h7F};
        send_stim();
        end_dl();
        check_status("zero_len", 1, 1'b0, 1'b1, 16'h4000, 16'h4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gtp_loader.md
Name: gtp_loader

Overview:
- Sits between hps_io and galaksija_top on the ioctl download path.
- Parses a GTP tape image streamed as ioctl bytes and decodes standard data blocks.
- Writes each payload byte into Galaksija RAM via a write-request handshake.
- Reports completion, error status and the load address range. Name and turbo blocks are skipped.

Parameters:
- ADDR_W, 16, RAM address width (Galaksija address space).
- MAX_BLOCKS, 255, blocks processed per download; further blocks are skipped.

Ports:
- clk_sys  in  1  system clock; same domain as hps_io.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle strobe; ioctl_dout valid.
- ioctl_dout  in  8  stream byte.
- ioctl_wait  out  1  back-pressure to hps_io; high while the holding register is full.
- mem_addr  out  ADDR_W  write address.
- mem_dout  out  8  write data.
- mem_req  out  1  write request; held until accepted.
- mem_ack  in  1  RAM accepts on the cycle where mem_req && mem_ack.
- load_done  out  1  pulse, one cycle, at download end when no error occurred.
- load_err  out  1  sticky error flag until the next download starts.
- start_addr  out  ADDR_W  start address of the first standard block.
- end_addr  out  ADDR_W  end address of the last standard block.

Behaviour:
- Reset values: all outputs 0; state IDLE; holding register empty.
- GTP block format (little-endian):
  - type byte: 0x00 standard, others skipped.
  - len lo, len hi.
  - two reserved bytes.
  - len payload bytes.
- Standard payload:
  - sync byte 0xA5.
  - start lo/hi.
  - end lo/hi.
  - (end - start) data bytes.
  - checksum byte.
- States: IDLE, TYPE, LEN_L, LEN_H, RSV0, RSV1, SYNC, ST_L, ST_H, EN_L, EN_H, DATA, CSUM, SKIP, ERROR.
  - IDLE -> TYPE on the rising edge of ioctl_download; clears load_err and the block counter.
  - Each ioctl_wr strobe advances one byte. A remaining-length counter (16-bit) is loaded in LEN_H and decremented per payload byte.
  - TYPE != 0x00, or block count >= MAX_BLOCKS: after RSV1, go to SKIP. Consume len bytes, then return to TYPE. len = 0 goes straight to TYPE.
  - SYNC byte != 0xA5 -> ERROR.
  - end < start -> ERROR.
  - (end - start + 6) != len -> ERROR.
  - DATA: each byte is latched into the holding register together with the address counter. mem_req rises on the next cycle. The address increments on mem_ack. After end - start bytes, go to CSUM.
  - end == start: go from EN_H directly to CSUM.
  - CSUM -> TYPE.
  - ERROR: sets load_err and consumes bytes until the download ends.
- Handshake:
  - Strobes are accepted only while the holding register is empty; an ioctl_wr arriving while it is full is a protocol violation (assertion).
  - ioctl_wait = holding full; it asserts the cycle after the latch and deasserts the cycle after mem_ack.
  - mem_addr/mem_dout are stable while mem_req is high.
  - Latency from strobe to mem_req is 1 cycle.
- Address counter wraps at 2^ADDR_W (0xFFFF+1 -> 0x0000); this is not an error.
- start_addr is captured on the first standard block only. end_addr is updated on every standard block.
- Falling edge of ioctl_download:
  - Byte-count check: the state must be TYPE with the holding register empty. Otherwise set load_err, since the file was truncated.
  - The final state check is evaluated once the pending RAM write completes.
  - load_done pulses only if load_err = 0; the FSM returns to IDLE.
- reset mid-download: FSM to IDLE, holding register cleared, mem_req dropped immediately. No further writes occur.
- Simultaneous mem_ack and a new strobe cannot occur (the wait protocol prevents it); if it does occur, the ack is processed first.

Optional Feature:
- Macro: GTP_CHECKSUM_EN.
- Defined:
  - 8-bit sum accumulates from ST_L through the checksum byte inclusive.
  - A sum != 0xFF in CSUM sets load_err; the FSM continues parsing the next block.
- Undefined: the checksum byte is consumed and ignored; there is no accumulator logic.

Decomposition:
- Package gtp_pkg holds:
  - state enum gtp_state_t.
  - GTP_TYPE_STD = 8'h00.
  - GTP_SYNC = 8'hA5.
  - GTP_HDR_BYTES = 5.
  - GTP_STD_OVERHEAD = 6.
- One sub-module, gtp_wr_buf: the single-entry holding register plus the mem_req/mem_ack/ioctl_wait handshake.

Test Plan:
- Single standard block, start=0x2C3A, end=0x2C3D, data 11 22 33, correct checksum, mem_ack immediate -> writes to 2C3A/2C3B/2C3C; start_addr=2C3A; end_addr=2C3D; load_done pulse; load_err=0.
- Name block (type 0x10, len 4) followed by a standard block -> name bytes produce no mem_req; the standard block is written.
- mem_ack delayed 5 cycles per write -> ioctl_wait high during each delay; addr/data stable; no byte lost.
- Bad sync byte 0x5A -> load_err=1; zero writes; no load_done.
- Truncated file (download ends mid-DATA) -> load_err=1; writes already issued remain; FSM returns to IDLE.
- GTP_CHECKSUM_EN defined, checksum off by one -> load_err=1. Undefined, same stimulus -> load_done pulse.
